// File: rtl/modexp_sequencer.sv
// ---------------------------------------------------------------------------
// modexp_sequencer
//
// Computes RESULT = BASE^EXP mod P by left-to-right square-and-multiply,
// driving a shared modular multiplier one operation at a time. P is the
// multiplier's built-in modulus, so this block never sees it.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             request pulse, accepted only while idle
//   base, exp         operands, sampled on an accepted start
//   busy              high while an accepted request is being worked on
//   done / err        one-cycle completion / watchdog-abort pulses
//   result            last completed value, held until overwritten
//   mul_in_valid      one-cycle issue pulse to the multiplier
//   mul_x, mul_y      multiplier operands, held from issue to response
//   mul_q             multiplier result
//   mul_out_valid     multiplier response strobe
// ---------------------------------------------------------------------------
module modexp_sequencer #(
  parameter int DATA_W  = 256,
  parameter int EXP_W   = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [EXP_W-1:0]  exp,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              mul_in_valid,
  output logic [DATA_W-1:0] mul_x,
  output logic [DATA_W-1:0] mul_y,
  input  logic [DATA_W-1:0] mul_q,
  input  logic              mul_out_valid
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQR_REQ,
    SQR_WAIT,
    MUL_REQ,
    MUL_WAIT,
    FIN,
    DONE
  } state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] base_reg;
  logic [EXP_W-1:0]  exp_reg;
  logic [DATA_W-1:0] acc_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [WD_W-1:0]   wd_reg;

  // Watchdog hits its limit on the cycle whose increment would reach TIMEOUT,
  // so err appears exactly TIMEOUT cycles after the issue pulse.
  logic wd_expire;
  assign wd_expire = (wd_reg == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      exp_reg      <= '0;
      acc_reg      <= '0;
      idx_reg      <= '0;
      wd_reg       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      result       <= '0;
      mul_in_valid <= 1'b0;
      mul_x        <= '0;
      mul_y        <= '0;
    end else begin
      // Pulse outputs default low; mul_x/mul_y intentionally keep their value.
      done         <= 1'b0;
      err          <= 1'b0;
      mul_in_valid <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (start) begin
            if (exp == '0) begin
              result    <= DATA_W'(1);
              state_reg <= DONE;
            end else begin
              base_reg  <= base;
              exp_reg   <= exp;
              idx_reg   <= IDX_W'(EXP_W - 1);
              busy      <= 1'b1;
              state_reg <= SCAN;
            end
          end
        end

        // Skip leading zeros; the first set bit seeds the accumulator.
        SCAN: begin
          if (exp_reg[idx_reg]) begin
            acc_reg <= base_reg;
            if (idx_reg == '0) begin
              result    <= base_reg;
              busy      <= 1'b0;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg - 1'b1;
              state_reg <= SQR_REQ;
            end
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end

        SQR_REQ: begin
          mul_x        <= acc_reg;
          mul_y        <= acc_reg;
          mul_in_valid <= 1'b1;
          wd_reg       <= '0;
          state_reg    <= SQR_WAIT;
        end

        // The index is consumed only after the optional multiply, so a set
        // bit goes to MUL_REQ without decrementing.
        SQR_WAIT: begin
          if (mul_out_valid) begin
            acc_reg <= mul_q;
            wd_reg  <= '0;
            if (exp_reg[idx_reg]) begin
              state_reg <= MUL_REQ;
            end else if (idx_reg == '0) begin
              state_reg <= FIN;
            end else begin
              idx_reg   <= idx_reg - 1'b1;
              state_reg <= SQR_REQ;
            end
          end else if (wd_expire) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end

        MUL_REQ: begin
          mul_x        <= acc_reg;
          mul_y        <= base_reg;
          mul_in_valid <= 1'b1;
          wd_reg       <= '0;
          state_reg    <= MUL_WAIT;
        end

        MUL_WAIT: begin
          if (mul_out_valid) begin
            acc_reg <= mul_q;
            wd_reg  <= '0;
            if (idx_reg == '0) begin
              state_reg <= FIN;
            end else begin
              idx_reg   <= idx_reg - 1'b1;
              state_reg <= SQR_REQ;
            end
          end else if (wd_expire) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end

        FIN: begin
          result    <= acc_reg;
          busy      <= 1'b0;
          state_reg <= DONE;
        end

        DONE: begin
          done      <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// ---------------------------------------------------------------------------
// tb_modexp_sequencer
//
// Scoreboard bench: each accepted request pushes its expected outcome and
// expected multiplier operand sequence; a monitor pops and compares whenever
// the DUT issues a multiply or reports done/err. A behavioural multiplier
// (X*Y mod 2^255-19, fixed latency) answers the DUT.
// ---------------------------------------------------------------------------
module tb_modexp_sequencer;
  localparam int DATA_W  = 256;
  localparam int EXP_W   = 256;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 5;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [DATA_W-1:0] base;
  logic [EXP_W-1:0]  exp;
  logic              busy, done, err, mul_in_valid;
  logic [DATA_W-1:0] result, mul_x, mul_y, mul_q;
  logic              mul_out_valid;

  modexp_sequencer #(.DATA_W(DATA_W), .EXP_W(EXP_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start), .base(base), .exp(exp),
    .busy(busy), .done(done), .err(err), .result(result),
    .mul_in_valid(mul_in_valid), .mul_x(mul_x), .mul_y(mul_y),
    .mul_q(mul_q), .mul_out_valid(mul_out_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails  = 0;
  int cycle    = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    bit           is_err;
    logic [255:0] res;
    int           n_ops;
    int           lat;
    int           start_cycle;
  } exp_t;

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
  } op_t;

  exp_t sb_q[$];
  op_t  op_q[$];
  int   ops_seen   = 0;
  int   last_issue = 0;
  bit   respond    = 1'b1;
  logic [255:0] last_res = '0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fails++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] pr;
    pr = {256'd0, a} * {256'd0, b};
    return 256'(pr % {256'd0, P});
  endfunction

  // Independent reference: right-to-left binary exponentiation.
  function automatic logic [255:0] ref_pow(input logic [255:0] b, input logic [255:0] e);
    logic [255:0] r, x;
    if (e == 0) return 256'd1;
    if (e == 1) return b;
    r = 256'd1;
    x = b;
    for (int j = 0; j < EXP_W; j++) begin
      if (e[j]) r = mulmod(r, x);
      x = mulmod(x, x);
    end
    return r;
  endfunction

  // Operand pairs the multiplier should see, in order.
  task automatic push_ops(input logic [255:0] b, input logic [255:0] e);
    int m;
    logic [255:0] acc;
    op_t o;
    m = -1;
    for (int j = 0; j < EXP_W; j++) if (e[j]) m = j;
    acc = b;
    for (int j = m - 1; j >= 0; j--) begin
      o.x = acc; o.y = acc; op_q.push_back(o);
      acc = mulmod(acc, acc);
      if (e[j]) begin
        o.x = acc; o.y = b; op_q.push_back(o);
        acc = mulmod(acc, b);
      end
    end
  endtask

  function automatic int expected_ops(input logic [255:0] e);
    int m;
    m = -1;
    for (int j = 0; j < EXP_W; j++) if (e[j]) m = j;
    if (m <= 0) return 0;
    return m + $countones(e) - 1;
  endfunction

  // Behavioural multiplier: out_valid LAT cycles after the issue pulse.
  logic [255:0] cap_x, cap_y;
  int  mcnt = 0;
  bit  pend = 1'b0;
  initial begin
    mul_out_valid = 1'b0;
    mul_q = '0;
    forever begin
      @(negedge clock);
      mul_out_valid = 1'b0;
      if (pend) begin
        if (busy) begin
          chk("mul_x_stable", mul_x, cap_x);
          chk("mul_y_stable", mul_y, cap_y);
        end
        mcnt--;
        if (mcnt == 0) begin
          mul_out_valid = 1'b1;
          mul_q = mulmod(cap_x, cap_y);
          pend = 1'b0;
        end
      end
      if (mul_in_valid && !reset && respond) begin
        cap_x = mul_x;
        cap_y = mul_y;
        mcnt = LAT;
        pend = 1'b1;
      end
    end
  end

  // Monitor / scoreboard checker.
  initial begin
    exp_t e;
    op_t  o;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mul_in_valid) begin
          ops_seen++;
          last_issue = cycle;
          if (op_q.size() == 0) flag("unexpected_mul_in_valid");
          else begin
            o = op_q.pop_front();
            chk("issue_mul_x", mul_x, o.x);
            chk("issue_mul_y", mul_y, o.y);
          end
        end
        if (done || err) begin
          if (sb_q.size() == 0) flag("unexpected_done_or_err");
          else begin
            e = sb_q.pop_front();
            chk("done_err_kind", {err, done}, e.is_err ? 2'b10 : 2'b01);
            chk("result", result, e.res);
            if (e.is_err) begin
              chk("watchdog_delay", cycle - last_issue, TIMEOUT);
              op_q.delete();
            end else begin
              chk("op_count", ops_seen, e.n_ops);
              chk("ops_left", op_q.size(), 0);
            end
            if (e.lat >= 0) chk("latency", cycle - e.start_cycle, e.lat);
            ops_seen = 0;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [255:0] b, input logic [255:0] e,
                          input bit push, input bit as_err, input int lat);
    exp_t x;
    @(negedge clock);
    start = 1'b1;
    base  = b;
    exp   = e;
    if (push) begin
      x.is_err      = as_err;
      x.res         = as_err ? last_res : ref_pow(b, e);
      x.n_ops       = expected_ops(e);
      x.lat         = lat;
      x.start_cycle = cycle;
      sb_q.push_back(x);
      push_ops(b, e);
      if (!as_err) last_res = x.res;
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_cnt);
    int n;
    n = 0;
    busy_cnt = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clock);
      n++;
      if (busy) busy_cnt++;
    end
    if (!(done || err)) flag("wait_done_timeout");
    @(negedge clock);
  endtask

  function automatic logic [255:0] rand_word();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int bc;
    int n;
    logic [255:0] b, e;
    reset = 1'b1;
    start = 1'b0;
    base  = '0;
    exp   = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_valid", mul_in_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_y", mul_y, 0);
    reset = 1'b0;

    // exp == 0: immediate result 1, no multiplier traffic.
    do_start(256'd7, 256'd0, 1, 0, 2);
    wait_done(50, bc);
    chk("exp0_busy_le1", bc <= 1, 1);

    // exp == 1: full leading-zero scan, no multiplier traffic.
    do_start(256'h1234, 256'd1, 1, 0, EXP_W + 2);
    wait_done(EXP_W + 20, bc);
    chk("exp1_result", result, 256'h1234);

    // 2^10 through three squarings and one multiply.
    do_start(256'd2, 256'd10, 1, 0, -1);
    wait_done(500, bc);
    chk("pow2_10", result, 256'd1024);

    // Start while busy must be ignored.
    do_start(256'd3, 256'd5, 1, 0, -1);
    repeat (3) @(negedge clock);
    chk("busy_mid_op", busy, 1);
    start = 1'b1; base = 256'd9; exp = 256'd3;
    @(negedge clock);
    start = 1'b0;
    wait_done(500, bc);
    chk("pow3_5", result, 256'd243);

    // Randomised requests, mostly short exponents plus one full-width.
    for (int t = 0; t < 8; t++) begin
      b = rand_word();
      e = rand_word();
      if (t < 7) e = e & ((256'd1 << $urandom_range(2, 14)) - 1);
      do_start(b, e, 1, 0, -1);
      wait_done(20000, bc);
    end

    // Multiplier goes silent: watchdog abort, result unchanged.
    respond = 1'b0;
    do_start(rand_word(), 256'd6, 1, 1, -1);
    wait_done(EXP_W + 100, bc);
    repeat (LAT + 4) @(negedge clock);
    respond = 1'b1;
    do_start(256'd5, 256'd3, 1, 0, -1);
    wait_done(500, bc);
    chk("after_timeout", result, 256'd125);

    // Reset while waiting on a square; the late response must be ignored.
    do_start(256'd11, 256'd13, 0, 0, -1);
    push_ops(256'd11, 256'd13);
    n = 0;
    while (!mul_in_valid && n < EXP_W + 20) begin
      @(negedge clock);
      n++;
    end
    if (!mul_in_valid) flag("reset_test_no_issue");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    op_q.delete();
    sb_q.delete();
    ops_seen = 0;
    last_res = '0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    chk("mr_in_valid", mul_in_valid, 0);
    chk("mr_result", result, 0);
    chk("mr_mul_x", mul_x, 0);
    repeat (LAT + 6) @(negedge clock);
    chk("mr_idle_result", result, 0);
    do_start(256'd7, 256'd2, 1, 0, -1);
    wait_done(500, bc);

    repeat (4) @(negedge clock);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule
